// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared types and constants for the microprogram sequencer.
// Holds the sequencer state enum, the micro-address width, the named
// micro-addresses of the control store and the opcode numbering.
package micro_seq_pkg;

    localparam int ADDR_W   = 5;
    localparam int OPCODE_W = 5;
    localparam int COUNT_W  = 16;

    typedef logic [ADDR_W-1:0]   uaddr_t;
    typedef logic [OPCODE_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Fixed points of the microprogram
    localparam uaddr_t FETCH1    = 5'd0;
    localparam uaddr_t FETCH2    = 5'd1;
    localparam uaddr_t OPEND1    = 5'd26;
    localparam uaddr_t NOP_ADDR  = 5'd31;

    // Microinstructions that touch memory and may have to wait for it
    localparam uaddr_t LOAD1     = 5'd19;
    localparam uaddr_t STORE1    = 5'd21;
    localparam uaddr_t STORE2    = 5'd22;

    // Entry points of the instruction routines
    localparam uaddr_t UA_RSTALL = 5'd2;
    localparam uaddr_t UA_CONST  = 5'd3;
    localparam uaddr_t UA_MOV    = 5'd4;
    localparam uaddr_t UA_SIZE   = 5'd5;
    localparam uaddr_t JMPNZY1   = 5'd9;
    localparam uaddr_t JMPNZN1   = 5'd11;
    localparam uaddr_t UA_OP4    = 5'd12;
    localparam uaddr_t UA_OP5    = 5'd13;
    localparam uaddr_t UA_ADDX   = 5'd14;
    localparam uaddr_t UA_ADDY   = 5'd15;
    localparam uaddr_t UA_ADD    = 5'd16;
    localparam uaddr_t UA_SUB    = 5'd17;
    localparam uaddr_t UA_MUL    = 5'd18;
    localparam uaddr_t UA_INCI   = 5'd24;
    localparam uaddr_t UA_RSTI   = 5'd25;

    // Opcode numbering; 17..31 are undefined
    localparam opcode_t OP_CONST  = 5'd0;
    localparam opcode_t OP_MOV    = 5'd1;
    localparam opcode_t OP_SIZE   = 5'd2;
    localparam opcode_t OP_JMPNZ  = 5'd3;
    localparam opcode_t OP_4      = 5'd4;
    localparam opcode_t OP_5      = 5'd5;
    localparam opcode_t OP_ADDX   = 5'd6;
    localparam opcode_t OP_ADDY   = 5'd7;
    localparam opcode_t OP_ADD    = 5'd8;
    localparam opcode_t OP_SUB    = 5'd9;
    localparam opcode_t OP_MUL    = 5'd10;
    localparam opcode_t OP_LOAD   = 5'd11;
    localparam opcode_t OP_STORE  = 5'd12;
    localparam opcode_t OP_INCI   = 5'd13;
    localparam opcode_t OP_RSTI   = 5'd14;
    localparam opcode_t OP_END    = 5'd15;
    localparam opcode_t OP_RSTALL = 5'd16;

    // True for microinstructions that must see mem_ready before advancing
    function automatic logic is_mem_uinst(input uaddr_t a);
        return (a == LOAD1) || (a == STORE1) || (a == STORE2);
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-unit side of the sequencer (start, opcode,
// flags, control-store next field, memory ready) and its status outputs.
// uinst_count exists only when MSEQ_PERF_EN is defined.
interface micro_sequencer_if;
    import micro_seq_pkg::*;

    logic    start;
    opcode_t opcode;
    logic    z_flag;
    uaddr_t  cs_next;
    logic    mem_ready;

    uaddr_t  addr;
    logic    running;
    logic    done;
    logic    illegal_op;
`ifdef MSEQ_PERF_EN
    logic [COUNT_W-1:0] uinst_count;
`endif

`ifdef MSEQ_PERF_EN
    // Control unit side: drives the sequencing inputs, observes status
    modport master (
        output start, opcode, z_flag, cs_next, mem_ready,
        input  addr, running, done, illegal_op, uinst_count
    );

    // Sequencer side
    modport slave (
        input  start, opcode, z_flag, cs_next, mem_ready,
        output addr, running, done, illegal_op, uinst_count
    );
`else
    // Control unit side: drives the sequencing inputs, observes status
    modport master (
        output start, opcode, z_flag, cs_next, mem_ready,
        input  addr, running, done, illegal_op
    );

    // Sequencer side
    modport slave (
        input  start, opcode, z_flag, cs_next, mem_ready,
        output addr, running, done, illegal_op
    );
`endif

endinterface

// File: rtl/micro_dispatch.sv
// micro_dispatch: combinational opcode decode used at FETCH2. Maps the
// opcode (and Z flag for JMPNZ) to the first micro-address of the routine,
// flagging undefined opcodes and sending them back to FETCH1.
module micro_dispatch
    import micro_seq_pkg::*;
(
    input  opcode_t opcode,
    input  logic    z_flag,
    output uaddr_t  target,
    output logic    illegal
);

    // Opcode to routine entry point; anything unlisted is undecodable
    always_comb begin
        target  = FETCH1;
        illegal = 1'b0;
        case (opcode)
            OP_CONST:  target = UA_CONST;
            OP_MOV:    target = UA_MOV;
            OP_SIZE:   target = UA_SIZE;
            OP_JMPNZ:  target = z_flag ? JMPNZN1 : JMPNZY1;
            OP_4:      target = UA_OP4;
            OP_5:      target = UA_OP5;
            OP_ADDX:   target = UA_ADDX;
            OP_ADDY:   target = UA_ADDY;
            OP_ADD:    target = UA_ADD;
            OP_SUB:    target = UA_SUB;
            OP_MUL:    target = UA_MUL;
            OP_LOAD:   target = LOAD1;
            OP_STORE:  target = STORE1;
            OP_INCI:   target = UA_INCI;
            OP_RSTI:   target = UA_RSTI;
            OP_END:    target = OPEND1;
            OP_RSTALL: target = UA_RSTALL;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: registers the current micro-address for the control
// store and picks the next one from the ROM next field, the opcode
// dispatch, the Z flag and memory readiness.
// Optional: define MSEQ_PERF_EN to add the uinst_count performance counter.
module micro_sequencer
    import micro_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    micro_sequencer_if.slave bus
);

    seq_state_t state_reg, state_next;
    uaddr_t     addr_reg, addr_next;
    logic       illegal_reg, illegal_next;

    uaddr_t     disp_target;
    logic       disp_illegal;

    micro_dispatch u_dispatch (
        .opcode  (bus.opcode),
        .z_flag  (bus.z_flag),
        .target  (disp_target),
        .illegal (disp_illegal)
    );

    // State, micro-address and illegal pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= NOP_ADDR;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            illegal_reg <= illegal_next;
        end
    end

    // Next state and next micro-address, rules checked in priority order
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        illegal_next = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                addr_next = NOP_ADDR;
                if (bus.start) begin
                    state_next = ST_RUN;
                    addr_next  = FETCH1;
                end
            end
            ST_RUN: begin
                if (addr_reg == NOP_ADDR) begin
                    // Execution should never land on the NOP slot
                    illegal_next = 1'b1;
                    addr_next    = FETCH1;
                end else if (addr_reg == OPEND1) begin
                    state_next = ST_DONE;
                    addr_next  = NOP_ADDR;
                end else if (is_mem_uinst(addr_reg) && !bus.mem_ready) begin
                    state_next = ST_WAIT;
                end else if (addr_reg == FETCH2) begin
                    addr_next    = disp_target;
                    illegal_next = disp_illegal;
                end else begin
                    addr_next = bus.cs_next;
                end
            end
            ST_WAIT: begin
                // The held address keeps the ROM word, so cs_next is still valid
                if (bus.mem_ready) begin
                    state_next = ST_RUN;
                    addr_next  = bus.cs_next;
                end
            end
            default: begin
                state_next = ST_IDLE;
                addr_next  = NOP_ADDR;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        bus.running = (state_reg == ST_RUN) || (state_reg == ST_WAIT);
        bus.done    = (state_reg == ST_DONE);
    end

    assign bus.addr       = addr_reg;
    assign bus.illegal_op = illegal_reg;

`ifdef MSEQ_PERF_EN
    logic               accept_start;
    logic               advance;
    logic [COUNT_W-1:0] count_reg;

    // A cycle counts when the sequencer moves on: any RUN cycle except the
    // one that stalls into WAIT, plus the WAIT cycle that releases
    assign accept_start = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && bus.start;
    assign advance = ((state_reg == ST_RUN) && !(is_mem_uinst(addr_reg) && !bus.mem_ready))
                   || ((state_reg == ST_WAIT) && bus.mem_ready);

    // Saturating executed-microinstruction counter, cleared per program run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (accept_start) begin
            count_reg <= '0;
        end else if (advance && (count_reg != {COUNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.uinst_count = count_reg;
`endif

endmodule
